// File: rtl/ucsbece154a_mem_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory: core (C) and DMA/debug (D).
// Define MEMARB_CORE_PRIORITY_EN for fixed core priority; the default is round-robin.
module ucsbece154a_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic              c_ack_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,

    output logic [ADDR_W-1:0] mem_a_o,
    output logic [DATA_W-1:0] mem_wd_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rd_i,

    output logic [1:0]        grant_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        G_NONE = 2'b00,
        G_CORE = 2'b01,
        G_DMA  = 2'b10
    } grant_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    grant_e            owner_q, owner_d;
    acc_t              acc_q, acc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic              c_ack_q, c_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              mem_we_q, mem_we_d;
    grant_e            grant_q, grant_d;

    logic              pick_core_c;
    acc_t              c_acc_c, d_acc_c;

    assign c_acc_c = '{we: c_we_i, addr: c_addr_i, wdata: c_wdata_i};
    assign d_acc_c = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i};

    // Winner selection; only consulted in IDLE when at least one request is up.
`ifdef MEMARB_CORE_PRIORITY_EN
    assign pick_core_c = c_req_i;
`else
    assign pick_core_c = c_req_i && (!d_req_i || (owner_q == G_DMA));
`endif

    // Next state and the next value of every registered output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        acc_d     = acc_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (c_req_i || d_req_i) begin
                    owner_d = pick_core_c ? G_CORE : G_DMA;
                    acc_d   = pick_core_c ? c_acc_c : d_acc_c;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (!acc_q.we) begin
                        rdata_d = mem_rd_i;
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so each pulse lines up with its state.
        c_ack_d   = (state_d == S_ACK) && (owner_d == G_CORE);
        d_ack_d   = (state_d == S_ACK) && (owner_d == G_DMA);
        c_rdata_d = c_ack_d ? rdata_d : c_rdata_q;
        d_rdata_d = d_ack_d ? rdata_d : d_rdata_q;
        mem_a_d   = (state_d != S_IDLE) ? acc_d.addr  : '0;
        mem_wd_d  = (state_d != S_IDLE) ? acc_d.wdata : '0;
        mem_we_d  = (state_d == S_BUSY) && acc_d.we && (cnt_d == '0);
        grant_d   = (state_d != S_IDLE) ? owner_d : G_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            owner_q   <= G_DMA;
            acc_q     <= '0;
            rdata_q   <= '0;
            c_rdata_q <= '0;
            c_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            d_ack_q   <= 1'b0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
            mem_we_q  <= 1'b0;
            grant_q   <= G_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            acc_q     <= acc_d;
            rdata_q   <= rdata_d;
            c_rdata_q <= c_rdata_d;
            c_ack_q   <= c_ack_d;
            d_rdata_q <= d_rdata_d;
            d_ack_q   <= d_ack_d;
            mem_a_q   <= mem_a_d;
            mem_wd_q  <= mem_wd_d;
            mem_we_q  <= mem_we_d;
            grant_q   <= grant_d;
        end
    end

    assign c_rdata_o = c_rdata_q;
    assign c_ack_o   = c_ack_q;
    assign d_rdata_o = d_rdata_q;
    assign d_ack_o   = d_ack_q;
    assign mem_a_o   = mem_a_q;
    assign mem_wd_o  = mem_wd_q;
    assign mem_we_o  = mem_we_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// Directed bench for ucsbece154a_mem_arbiter: main instance at LATENCY=3, second instance at LATENCY=1.
module tb_ucsbece154a_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned L  = 3;
    localparam logic [31:0] GARBAGE = 32'h0BAD_F00D;

    logic          clk = 1'b0;
    logic          reset;

    logic          c_req_i, c_we_i, d_req_i, d_we_i;
    logic [AW-1:0] c_addr_i, d_addr_i, mem_a_o;
    logic [DW-1:0] c_wdata_i, d_wdata_i, c_rdata_o, d_rdata_o, mem_wd_o, mem_rd_i;
    logic          c_ack_o, d_ack_o, mem_we_o;
    logic [1:0]    grant_o;

    logic          b_c_req, b_c_we, b_d_req, b_d_we;
    logic [AW-1:0] b_c_addr, b_d_addr, b_mem_a;
    logic [DW-1:0] b_c_wdata, b_d_wdata, b_c_rdata, b_d_rdata, b_mem_wd, b_mem_rd;
    logic          b_c_ack, b_d_ack, b_mem_we;
    logic [1:0]    b_grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run observations
    int          cyc_c, cyc_d, we_pulses, we_cyc, ack_cnt_c, ack_cnt_d;
    logic [31:0] we_a, we_d, a_first, c_rd, d_rd;
    logic [1:0]  g_first;
    bit          a_stable;
    int          rd_at = 0, chg_at = 0, d_raise_at = 0;
    logic [31:0] rd_val = '0, chg_addr = '0;

    always #5 clk = ~clk;

    ucsbece154a_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L)) u_dut (
        .clk(clk), .reset(reset),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
        .c_rdata_o(c_rdata_o), .c_ack_o(c_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
        .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o), .mem_we_o(mem_we_o), .mem_rd_i(mem_rd_i),
        .grant_o(grant_o)
    );

    ucsbece154a_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .c_req_i(b_c_req), .c_we_i(b_c_we), .c_addr_i(b_c_addr), .c_wdata_i(b_c_wdata),
        .c_rdata_o(b_c_rdata), .c_ack_o(b_c_ack),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_rdata_o(b_d_rdata), .d_ack_o(b_d_ack),
        .mem_a_o(b_mem_a), .mem_wd_o(b_mem_wd), .mem_we_o(b_mem_we), .mem_rd_i(b_mem_rd),
        .grant_o(b_grant)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From an ACK cycle, step into IDLE and confirm the bus is released.
    task automatic idle_gap(input string tag);
        tick();
        check({tag, "_idle_grant"}, grant_o, 2'b00);
        check({tag, "_idle_acks"}, {c_ack_o, d_ack_o}, 2'b00);
    endtask

    // Raise requests in the current IDLE cycle and step until the requested acks arrive.
    task automatic run(input bit c_en, input bit d_en, input bit c_repeat, input int budget);
        int n;
        bit pend_c, pend_d, d_got;
        n = 0; pend_c = c_en; pend_d = d_en; d_got = 0;
        cyc_c = 0; cyc_d = 0; we_pulses = 0; we_cyc = 0; we_a = '0; we_d = '0;
        ack_cnt_c = 0; ack_cnt_d = 0; a_stable = 1; g_first = '0; a_first = '0;
        c_rd = '0; d_rd = '0;
        c_req_i = c_en; d_req_i = d_en;
        while (n < budget && (c_repeat ? !d_got : (pend_c || pend_d))) begin
            tick();
            n++;
            mem_rd_i = (n == rd_at) ? rd_val : GARBAGE;
            if (n == chg_at) c_addr_i = chg_addr;
            if (n == d_raise_at) begin d_req_i = 1'b1; pend_d = 1; end
            if (n == 1) begin
                g_first = grant_o;
                a_first = mem_a_o;
            end else if (grant_o != 2'b00 && mem_a_o != a_first) begin
                a_stable = 0;
            end
            if (mem_we_o) begin
                we_pulses++; we_cyc = n; we_a = mem_a_o; we_d = mem_wd_o;
            end
            if (c_ack_o) begin
                ack_cnt_c++;
                if (pend_c) begin
                    if (cyc_c == 0) cyc_c = n;
                    c_rd = c_rdata_o;
                    if (!c_repeat) begin pend_c = 0; c_req_i = 1'b0; end
                end
            end
            if (d_ack_o) begin
                ack_cnt_d++;
                if (pend_d) begin
                    cyc_d = n; d_rd = d_rdata_o; pend_d = 0; d_got = 1; d_req_i = 1'b0;
                end
            end
        end
        if (c_repeat) begin
            c_req_i = 1'b0;
            d_req_i = 1'b0;
        end else begin
            check("run_timeout", {pend_c, pend_d}, 2'b00);
        end
        rd_at = 0; chg_at = 0; d_raise_at = 0;
        mem_rd_i = GARBAGE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit we_seen, ack_seen;

        reset = 1'b1;
        c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 32'h400; c_wdata_i = '0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500; d_wdata_i = '0;
        mem_rd_i = GARBAGE;
        b_c_req = 1'b0; b_c_we = 1'b0; b_c_addr = '0; b_c_wdata = '0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        b_mem_rd = 32'h1357_9BDF;

        // Requests held high through reset must be ignored.
        repeat (3) tick();
        check("rst_grant_in_reset", grant_o, 2'b00);
        reset = 1'b0;
        check("rst_grant", grant_o, 2'b00);
        check("rst_acks", {c_ack_o, d_ack_o}, 2'b00);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_a", mem_a_o, 32'h0);
        check("rst_mem_wd", mem_wd_o, 32'h0);
        check("rst_rdata", {c_rdata_o, d_rdata_o}, 64'h0);

        // First tie after reset: core first, DMA after.
        run(1, 1, 0, 30);
        check("pair1_grant_first", g_first, 2'b01);
        check("pair1_c_ack_cyc", cyc_c, 4);
        check("pair1_d_ack_cyc", cyc_d, 9);
        idle_gap("pair1");

        // Core read with an address change during BUSY.
        c_addr_i = 32'h40; c_we_i = 1'b0;
        rd_at = L; rd_val = 32'hDEAD_BEEF; chg_at = 1; chg_addr = 32'h80;
        run(1, 0, 0, 20);
        check("crd_ack_cyc", cyc_c, 4);
        check("crd_rdata", c_rd, 32'hDEAD_BEEF);
        check("crd_no_we", we_pulses, 0);
        check("crd_grant", g_first, 2'b01);
        check("crd_addr", a_first, 32'h40);
        check("crd_addr_stable", a_stable, 1'b1);
        check("crd_no_d_ack", ack_cnt_d, 0);
        idle_gap("crd");

        // DMA write: single strobe in the last BUSY cycle.
        d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'h1234_5678;
        run(0, 1, 0, 20);
        check("dwr_we_pulses", we_pulses, 1);
        check("dwr_we_cyc", we_cyc, 3);
        check("dwr_we_addr", we_a, 32'h100);
        check("dwr_we_data", we_d, 32'h1234_5678);
        check("dwr_ack_cyc", cyc_d, 4);
        check("dwr_c_rdata_hold", c_rdata_o, 32'hDEAD_BEEF);
        idle_gap("dwr");

        // Core write leaves the core as last owner.
        c_we_i = 1'b1; c_addr_i = 32'h200; c_wdata_i = 32'hCAFE_F00D;
        run(1, 0, 0, 20);
        check("cwr_we_pulses", we_pulses, 1);
        check("cwr_we_addr", we_a, 32'h200);
        check("cwr_we_data", we_d, 32'hCAFE_F00D);
        check("cwr_ack_cyc", cyc_c, 4);
        idle_gap("cwr");

        // Second tie, core served last.
        c_we_i = 1'b0; c_addr_i = 32'h240; d_we_i = 1'b0; d_addr_i = 32'h140;
        rd_at = L; rd_val = 32'hA5A5_5A5A;
        run(1, 1, 0, 30);
`ifdef MEMARB_CORE_PRIORITY_EN
        check("pair2_c_first", cyc_c, 4);
        check("pair2_d_second", cyc_d, 9);
        check("pair2_c_rdata", c_rd, 32'hA5A5_5A5A);
`else
        check("pair2_d_first", cyc_d, 4);
        check("pair2_c_second", cyc_c, 9);
        check("pair2_d_rdata", d_rd, 32'hA5A5_5A5A);
        check("pair2_c_rdata", c_rd, GARBAGE);
`endif
        idle_gap("pair2");

        // Core re-requests continuously; DMA arrives while the core is BUSY.
        d_raise_at = 1;
        run(1, 0, 1, 49);
        check("starve_grant_first", g_first, 2'b01);
`ifdef MEMARB_CORE_PRIORITY_EN
        check("starve_no_d_ack", ack_cnt_d, 0);
        check("starve_c_acks", ack_cnt_c, 10);
`else
        check("fair_d_ack_cyc", cyc_d, 9);
        check("fair_c_acks", ack_cnt_c, 1);
`endif
        idle_gap("starve");

        // Reset lands on the edge ending the second BUSY cycle of a write.
        c_we_i = 1'b1; c_addr_i = 32'h300; c_wdata_i = 32'h1;
        c_req_i = 1'b1;
        we_seen = 0; ack_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 2) reset = 1'b1;
            if (i == 3) begin
                reset = 1'b0;
                c_req_i = 1'b0;
                check("rstmid_grant", grant_o, 2'b00);
                check("rstmid_mem_a", mem_a_o, 32'h0);
            end
            we_seen  = we_seen | mem_we_o;
            ack_seen = ack_seen | c_ack_o | d_ack_o;
        end
        check("rstmid_no_we", we_seen, 1'b0);
        check("rstmid_no_ack", ack_seen, 1'b0);

        // LATENCY=1 instance: single BUSY cycle carrying the write strobe.
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h10; b_d_wdata = 32'h55AA_33CC;
        tick();
        check("l1_dwr_we", b_mem_we, 1'b1);
        check("l1_dwr_addr", b_mem_a, 32'h10);
        check("l1_dwr_data", b_mem_wd, 32'h55AA_33CC);
        check("l1_dwr_grant", b_grant, 2'b10);
        tick();
        check("l1_dwr_ack", b_d_ack, 1'b1);
        check("l1_dwr_we_off", b_mem_we, 1'b0);
        b_d_req = 1'b0;
        tick();
        check("l1_idle", {b_d_ack, b_grant}, 3'b000);
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 32'h14;
        tick();
        check("l1_crd_grant", b_grant, 2'b01);
        check("l1_crd_no_we", b_mem_we, 1'b0);
        tick();
        check("l1_crd_ack", b_c_ack, 1'b1);
        check("l1_crd_rdata", b_c_rdata, 32'h1357_9BDF);
        b_c_req = 1'b0;
        tick();
        check("l1_crd_ack_once", b_c_ack, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ucsbece154a_mem_arbiter.md
Name: ucsbece154a_mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between two requesters.
  - Port C: the multicycle core's memory interface.
  - Port D: a DMA/debug loader that fills and inspects memory.
- Sits between the core datapath's Adr/WriteData/ReadData nets and the memory macro.
- Serializes accesses and holds a requester until its access completes.
- Absorbs a fixed, configurable memory access latency.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width.
- LATENCY, 1, memory cycles per access; legal range 1..15. The internal down-counter is 4 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- c_req_i  in  1  core access request; held until c_ack_o
- c_we_i  in  1  core write enable (1 = write)
- c_addr_i  in  ADDR_W  core address
- c_wdata_i  in  DATA_W  core write data
- c_rdata_o  out  DATA_W  core read data; valid while c_ack_o=1
- c_ack_o  out  1  one-cycle completion pulse for the core
- d_req_i, d_we_i, d_addr_i, d_wdata_i  in  1/1/ADDR_W/DATA_W  DMA port; same meaning as the core port
- d_rdata_o  out  DATA_W  DMA read data
- d_ack_o  out  1  DMA completion pulse
- mem_a_o  out  ADDR_W  memory address
- mem_wd_o  out  DATA_W  memory write data
- mem_we_o  out  1  memory write strobe
- mem_rd_i  in  DATA_W  memory read data; valid in the last BUSY cycle
- grant_o  out  2  current owner: 01 = core, 10 = DMA, 00 = none

Behaviour:
- Clocking: one clock domain. reset is synchronous and active-high. All state updates occur on the posedge of clk.
- Reset values:
  - state = IDLE, cnt = 0.
  - last_grant = DMA, so the core wins the first tie.
  - Latched addr/wdata/we = 0, rdata register = 0.
  - All outputs 0.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - grant_o = 00, mem_we_o = 0, mem_a_o = 0.
  - If any req is high, choose a winner and latch its addr, wdata and we.
  - Set cnt = LATENCY-1, record the winner in owner/last_grant, then go to BUSY.
  - If only one request is high, that port wins.
  - If both are high (round-robin), the port not in last_grant wins.
  - If no request, stay in IDLE.
- BUSY:
  - mem_a_o = latched addr, mem_wd_o = latched wdata, grant_o = owner.
  - mem_we_o = latched we AND (cnt==0). The write strobe is high for exactly one cycle per write access.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, register mem_rd_i into the rdata register (reads only; writes leave it unchanged) and go to ACK.
- ACK:
  - Owner's ack_o = 1 for exactly one cycle. The owner's rdata_o = rdata register.
  - The non-owner's ack_o = 0 and its rdata_o holds its last value.
  - Next state is always IDLE.
- Latency: req is seen in IDLE at cycle t, BUSY occupies cycles t+1..t+LATENCY, and ack arrives at cycle t+1+LATENCY. Total is LATENCY+1 cycles for an uncontended request.
- Handshake rules:
  - A requester keeps req and its fields stable until it sees ack. Fields are latched at grant, so changes after grant are ignored.
  - A requester deasserts req on the edge where it samples ack. If req is still high in the following IDLE cycle, it is treated as a new request.
  - Requests from the losing port persist; the loser is served in the next IDLE cycle.
- Boundary conditions:
  - Both requests arriving while BUSY: no effect until IDLE. Arbitration happens only in IDLE.
  - Back-to-back requests from one port with the other idle: that port is granted repeatedly. There is no forced idle beyond the ACK→IDLE cycle.
  - Reset during BUSY: the access is abandoned at that edge. If the reset edge precedes the cnt==0 cycle, mem_we_o is never asserted, and no ack is issued.
  - Reset during ACK: the ack pulse is cut at the reset edge.
  - LATENCY = 1: BUSY lasts exactly one cycle, and mem_we_o is asserted in that cycle.
  - d_req_i/c_req_i high during reset: ignored. Arbitration starts in the first IDLE cycle after reset deasserts.

Optional Feature:
- Macro: MEMARB_CORE_PRIORITY_EN.
- Defined: fixed priority. When both ports request in IDLE, the core always wins. last_grant is still tracked for grant_o, but it does not influence arbitration. The DMA may starve while the core requests continuously.
- Undefined (default): round-robin as described above. Neither port can be starved; each waits at most one access of the other port.

Test Plan:
- LATENCY=2, core read only: c_req_i=1, addr=0x40, mem_rd_i=0xDEADBEEF in the last BUSY cycle → c_ack_o pulses exactly 3 cycles after req is sampled; c_rdata_o=0xDEADBEEF; mem_we_o stays 0; grant_o = 01 during BUSY.
- DMA write, LATENCY=3: d_we_i=1, addr=0x100, wdata=0x12345678 → mem_we_o is high for exactly 1 cycle (the third BUSY cycle) with mem_a_o=0x100 and mem_wd_o=0x12345678; d_ack_o pulses the next cycle.
- Simultaneous requests after reset, macro undefined: both req held → core is served first (ack at +LATENCY+1), then the DMA. A second simultaneous pair after that is served DMA first, then core (alternation).
- Same as the previous case with MEMARB_CORE_PRIORITY_EN: core re-requests immediately after every ack → d_ack_o never asserts over 10 core accesses.
- Reset mid-write: LATENCY=4, reset asserted in the second BUSY cycle → state returns to IDLE, mem_we_o is never 1, no ack pulse, and grant_o=00 on the next cycle.
- Field change after grant: core changes c_addr_i from 0x40 to 0x80 during BUSY → mem_a_o stays 0x40 until ack.
